// File: rtl/rst_event_sense_pkg.sv
// ----------------------------------------------------------------------------
// rst_event_sense_pkg
//   Shared types and helpers for the foreign-reset event monitor.
//   Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package rst_event_sense_pkg;

  // Monitor FSM states
  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_IDLE     = 2'd1,
    ST_ASSERTED = 2'd2
  } state_e;

  // Bits needed to hold the saturating width counter value MIN_ASSERT
  function automatic int width_bits(input int min_assert);
    return $clog2(min_assert + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rst_sense_sync.sv
// ----------------------------------------------------------------------------
// rst_sense_sync
//   Reset synchroniser for a foreign active-low reset. The chain is cleared
//   asynchronously by either the local or the foreign reset, so assertion is
//   seen immediately and deassertion is released through SYNC_STAGES flops.
//   Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rst_sense_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic IN_RST,
  output logic SYNC_O
);

  logic                   w_clr_n;
  logic [SYNC_STAGES-1:0] chain_q;

  assign w_clr_n = RST & IN_RST;

  // Shift ones in once both resets are released; clear asynchronously otherwise
  always_ff @(posedge CLK or negedge w_clr_n) begin
    if (!w_clr_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign SYNC_O = chain_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/rst_event_sense.sv
// ----------------------------------------------------------------------------
// rst_event_sense
//   Destination-side monitor for a foreign asynchronous reset: synchronises
//   IN_RST, measures each assertion width, posts completed assertions as
//   valid/ready events, flags short assertions and event overruns.
//   Optional macro: RST_EVENT_COUNT_EN builds the EVT_COUNT register;
//   without it EVT_COUNT is tied to zero.
//   Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rst_event_sense
  import rst_event_sense_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_ASSERT  = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_RST,
  output logic                 IN_RESET,
  output logic                 EVT_VALID,
  input  logic                 EVT_READY,
  output logic [CNT_WIDTH-1:0] EVT_COUNT,
  output logic                 EVT_SHORT,
  output logic                 OVERRUN,
  input  logic                 CLR_STICKY
);

  localparam int              WW    = width_bits(MIN_ASSERT);
  localparam logic [WW-1:0]   MIN_W = WW'(MIN_ASSERT);

  logic          w_sync;
  logic          w_done;
  logic          w_evt;
  logic          w_short;

  state_e        state_q;
  logic [WW-1:0] width_q;

  logic          evt_valid_q, evt_valid_d;
  logic          short_q,     short_d;
  logic          overrun_q,   overrun_d;

  rst_sense_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK    (CLK),
    .RST    (RST),
    .IN_RST (IN_RST),
    .SYNC_O (w_sync)
  );

  // Assertion is reported as soon as the chain is cleared
  assign IN_RESET = ~w_sync;

  // An assertion completes when the FSM sees sync return high
  assign w_done  = (state_q == ST_ASSERTED) && w_sync;
  assign w_evt   = w_done && (width_q >= MIN_W);
  assign w_short = w_done && (width_q <  MIN_W);

  // Monitor FSM with saturating assertion-width counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_BOOT;
      width_q <= '0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          if (w_sync) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!w_sync) begin
            state_q <= ST_ASSERTED;
            width_q <= WW'(1);
          end
        end
        ST_ASSERTED: begin
          if (w_sync) begin
            state_q <= ST_IDLE;
          end else if (width_q < MIN_W) begin
            width_q <= width_q + WW'(1);
          end
        end
        default: state_q <= ST_BOOT;
      endcase
    end
  end

  // Next-state for the event handshake and sticky flags; a set beats a clear
  always_comb begin
    evt_valid_d = evt_valid_q;
    if (w_evt) begin
      evt_valid_d = 1'b1;
    end else if (evt_valid_q && EVT_READY) begin
      evt_valid_d = 1'b0;
    end

    short_d = short_q;
    if (w_short) begin
      short_d = 1'b1;
    end else if (CLR_STICKY) begin
      short_d = 1'b0;
    end

    overrun_d = overrun_q;
    if (w_evt && evt_valid_q && !EVT_READY) begin
      overrun_d = 1'b1;
    end else if (CLR_STICKY) begin
      overrun_d = 1'b0;
    end
  end

  // Event and sticky flag registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      evt_valid_q <= 1'b0;
      short_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      evt_valid_q <= evt_valid_d;
      short_q     <= short_d;
      overrun_q   <= overrun_d;
    end
  end

  assign EVT_VALID = evt_valid_q;
  assign EVT_SHORT = short_q;
  assign OVERRUN   = overrun_q;

`ifdef RST_EVENT_COUNT_EN
  logic [CNT_WIDTH-1:0] count_q;

  // Wrapping count of valid events
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_q <= '0;
    end else if (w_evt) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign EVT_COUNT = count_q;
`else
  assign EVT_COUNT = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rst_event_sense.sv
// ----------------------------------------------------------------------------
// tb_rst_event_sense
//   Self-checking bench for rst_event_sense (CNT_WIDTH=2 to reach the wrap).
//   Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_rst_event_sense;

  localparam int CW = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          IN_RST;
  logic          IN_RESET;
  logic          EVT_VALID;
  logic          EVT_READY;
  logic [CW-1:0] EVT_COUNT;
  logic          EVT_SHORT;
  logic          OVERRUN;
  logic          CLR_STICKY;

  int checks   = 0;
  int failures = 0;
  int model_cnt = 0;
  int exp_q[$];

  typedef struct {
    int low;
    bit exp_evt;
    bit exp_short;
  } vec_t;

  vec_t vecs[6];

  rst_event_sense #(
    .SYNC_STAGES (2),
    .MIN_ASSERT  (4),
    .CNT_WIDTH   (CW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IN_RST     (IN_RST),
    .IN_RESET   (IN_RESET),
    .EVT_VALID  (EVT_VALID),
    .EVT_READY  (EVT_READY),
    .EVT_COUNT  (EVT_COUNT),
    .EVT_SHORT  (EVT_SHORT),
    .OVERRUN    (OVERRUN),
    .CLR_STICKY (CLR_STICKY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected counter value for the current build
  function automatic int exp_count();
`ifdef RST_EVENT_COUNT_EN
    return model_cnt % (1 << CW);
`else
    return 0;
`endif
  endfunction

  task automatic note_event();
    model_cnt++;
    exp_q.push_back(exp_count());
  endtask

  task automatic pulse(input int low);
    IN_RST = 1'b0;
    repeat (low) tick();
    IN_RST = 1'b1;
  endtask

  // Watch n cycles: first EVT_VALID tick, valid cycles, IN_RESET fall tick.
  // Accepted events are compared against the scoreboard queue.
  task automatic monitor(input int n, output int first_v, output int nvalid,
                         output int fall);
    first_v = 0;
    nvalid  = 0;
    fall    = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (!IN_RESET && fall == 0) fall = i;
      if (EVT_VALID) begin
        nvalid++;
        if (first_v == 0) first_v = i;
        if (EVT_READY) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_event", 1, 0);
          end else begin
            check("sb_evt_count", int'(EVT_COUNT), exp_q.pop_front());
          end
        end
      end
    end
  endtask

  initial begin
    int fv, nv, fl;

    vecs[0] = '{low: 1,  exp_evt: 1'b0, exp_short: 1'b1};
    vecs[1] = '{low: 2,  exp_evt: 1'b1, exp_short: 1'b0};
    vecs[2] = '{low: 3,  exp_evt: 1'b1, exp_short: 1'b0};
    vecs[3] = '{low: 10, exp_evt: 1'b1, exp_short: 1'b0};
    vecs[4] = '{low: 5,  exp_evt: 1'b1, exp_short: 1'b0};
    vecs[5] = '{low: 4,  exp_evt: 1'b1, exp_short: 1'b0};

    RST        = 1'b0;
    IN_RST     = 1'b1;
    EVT_READY  = 1'b1;
    CLR_STICKY = 1'b0;

    // Local reset
    repeat (3) tick();
    check("rst_in_reset", IN_RESET, 1);
    check("rst_evt_valid", EVT_VALID, 0);
    check("rst_evt_count", int'(EVT_COUNT), 0);
    check("rst_evt_short", EVT_SHORT, 0);
    check("rst_overrun", OVERRUN, 0);
    RST = 1'b1;
    monitor(5, fv, nv, fl);
    check("boot_in_reset_fall", fl, 2);
    check("boot_no_event", nv, 0);

    // Table-driven assertion widths with EVT_READY held high
    foreach (vecs[k]) begin
      if (vecs[k].exp_evt) note_event();
      pulse(vecs[k].low);
      monitor(6, fv, nv, fl);
      check($sformatf("v%0d_valid_cycles", k), nv, vecs[k].exp_evt ? 1 : 0);
      check($sformatf("v%0d_first_valid", k), fv, vecs[k].exp_evt ? 3 : 0);
      check($sformatf("v%0d_in_reset_fall", k), fl, 2);
      check($sformatf("v%0d_short", k), EVT_SHORT, vecs[k].exp_short);
      check($sformatf("v%0d_count", k), int'(EVT_COUNT), exp_count());
      CLR_STICKY = 1'b1;
      tick();
      CLR_STICKY = 1'b0;
    end
    check("sb_drained", exp_q.size(), 0);

    // Sub-cycle glitch reads as a short assertion
    IN_RST = 1'b0;
    #0.5;
    check("glitch_async_assert", IN_RESET, 1);
    #0.5;
    IN_RST = 1'b1;
    monitor(5, fv, nv, fl);
    check("glitch_in_reset_fall", fl, 2);
    check("glitch_no_event", nv, 0);
    check("glitch_short", EVT_SHORT, 1);
    check("glitch_count", int'(EVT_COUNT), exp_count());
    CLR_STICKY = 1'b1;
    tick();
    CLR_STICKY = 1'b0;
    check("glitch_short_cleared", EVT_SHORT, 0);

    // Set and clear in the same cycle: set wins, clear applies afterwards
    CLR_STICKY = 1'b1;
    IN_RST = 1'b0;
    #1;
    IN_RST = 1'b1;
    monitor(3, fv, nv, fl);
    check("setclr_short_set", EVT_SHORT, 1);
    tick();
    check("setclr_short_cleared", EVT_SHORT, 0);
    CLR_STICKY = 1'b0;

    // Overrun: two events without acceptance coalesce
    EVT_READY = 1'b0;
    pulse(4);
    model_cnt++;
    repeat (4) tick();
    check("ovr_first_valid", EVT_VALID, 1);
    check("ovr_no_overrun_yet", OVERRUN, 0);
    pulse(4);
    model_cnt++;
    repeat (3) tick();
    check("ovr_valid_held", EVT_VALID, 1);
    check("ovr_overrun", OVERRUN, 1);
    check("ovr_count", int'(EVT_COUNT), exp_count());
    EVT_READY = 1'b1;
    tick();
    check("ovr_accepted", EVT_VALID, 0);
    check("ovr_overrun_sticky", OVERRUN, 1);
    CLR_STICKY = 1'b1;
    tick();
    CLR_STICKY = 1'b0;
    check("ovr_cleared", OVERRUN, 0);

    // Acceptance coinciding with a new event: stays valid, no overrun
    EVT_READY = 1'b0;
    pulse(4);
    model_cnt++;
    repeat (4) tick();
    check("coin_pending", EVT_VALID, 1);
    pulse(4);
    model_cnt++;
    repeat (2) tick();
    EVT_READY = 1'b1;
    tick();
    check("coin_valid_stays", EVT_VALID, 1);
    check("coin_no_overrun", OVERRUN, 0);
    check("coin_count", int'(EVT_COUNT), exp_count());
    tick();
    check("coin_accepted", EVT_VALID, 0);

    // Local reset while an event is pending and IN_RST is asserted
    EVT_READY = 1'b0;
    pulse(4);
    model_cnt++;
    repeat (4) tick();
    check("midrst_pending", EVT_VALID, 1);
    IN_RST = 1'b0;
    repeat (2) tick();
    RST = 1'b0;
    #1;
    model_cnt = 0;
    check("midrst_valid", EVT_VALID, 0);
    check("midrst_count", int'(EVT_COUNT), 0);
    check("midrst_in_reset", IN_RESET, 1);
    check("midrst_short", EVT_SHORT, 0);
    IN_RST = 1'b1;
    EVT_READY = 1'b1;
    repeat (3) tick();
    RST = 1'b1;
    monitor(6, fv, nv, fl);
    check("midrst_no_event", nv, 0);
    check("midrst_no_short", EVT_SHORT, 0);
    check("midrst_in_reset_fall", fl, 2);

    // Five valid events from a fresh count wrap a 2-bit counter to 1
    for (int p = 0; p < 5; p++) begin
      note_event();
      pulse(3);
      monitor(5, fv, nv, fl);
      check($sformatf("wrap%0d_valid_cycles", p), nv, 1);
    end
    check("wrap_count", int'(EVT_COUNT), exp_count());
    check("wrap_sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rst_event_sense.md
# rst_event_sense

Destination-side monitor for a foreign asynchronous reset. It synchronises an incoming active-low reset (IN_RST) from another clock domain into CLK, and reports its level. Each completed assertion/deassertion cycle is posted as a valid/ready event to local control logic. Assertions shorter than a minimum width are flagged as glitches, and events arriving while one is still pending are flagged as overruns. It is the consuming end of a cross-domain reset generator.

## Interface
- SYNC_STAGES, 2: synchroniser depth, ≥2.
- MIN_ASSERT, 4: minimum synchronised low width, in CLK cycles, for a valid event; must exceed SYNC_STAGES.
- CNT_WIDTH, 8: event counter width.

Ports:
- CLK  in  1  local clock.
- RST  in  1  local reset, asynchronous, active-low.
- IN_RST  in  1  foreign reset, asynchronous, active-low.
- IN_RESET  out  1  1 while the synchronised IN_RST is asserted.
- EVT_VALID  out  1  a valid reset event is pending.
- EVT_READY  in  1  consumer accepts the event.
- EVT_COUNT  out  CNT_WIDTH  count of valid events, wraps modulo 2^CNT_WIDTH.
- EVT_SHORT  out  1  sticky: an assertion shorter than MIN_ASSERT was seen.
- OVERRUN  out  1  sticky: a valid event completed while EVT_VALID=1 and EVT_READY=0.
- CLR_STICKY  in  1  clears EVT_SHORT and OVERRUN.

## Operation
- Synchroniser chain, SYNC_STAGES flops:
  - Asynchronously cleared to 0 when RST=0 or IN_RST=0.
  - Otherwise shifts in 1.
  - sync = last stage.
  - IN_RESET = !sync, so assertion is asynchronous and deassertion is synchronous.
- FSM states and transitions:
  - BOOT: reset state. Goes to IDLE when sync=1. Never posts events.
  - IDLE: goes to ASSERTED when sync=0; width<=1.
  - ASSERTED: while sync=0, width increments and saturates at MIN_ASSERT. When sync=1, goes to IDLE and:
    - width≥MIN_ASSERT: valid event.
    - width<MIN_ASSERT: EVT_SHORT<=1.
- Valid event:
  - EVT_VALID<=1.
  - EVT_COUNT<=EVT_COUNT+1, wrapping.
  - If EVT_VALID=1 and EVT_READY=0 in that cycle: OVERRUN<=1 and the events coalesce (EVT_VALID stays 1).
- Handshake:
  - EVT_VALID clears on an edge with EVT_VALID=1 and EVT_READY=1, unless a new valid event completes in the same cycle, in which case it stays 1 and OVERRUN is not set.
  - EVT_READY is ignored while EVT_VALID=0.
- Sticky flags: CLR_STICKY=1 clears both. If a set and a clear coincide in the same cycle, the set wins.
- Width counter width: bits needed to hold MIN_ASSERT.
- Reset values, RST=0:
  - State BOOT, width 0.
  - EVT_VALID, EVT_COUNT, EVT_SHORT, OVERRUN all 0.
  - IN_RESET 1, because the chain is cleared.
- RST asserted mid-operation: everything returns to BOOT immediately. A pending event is discarded and the count is lost.

## Timing
- IN_RST falling: IN_RESET rises asynchronously, with no clock required.
- IN_RST rising before edge k: sync=1 and IN_RESET=0 after edge k+SYNC_STAGES-1.
- The FSM samples sync at the next edge. EVT_VALID rises one cycle after IN_RESET falls.
- Minimum observable width is SYNC_STAGES cycles, even for a sub-cycle glitch. With the defaults, a glitch reads as width 2 < 4 and is flagged short.
- EVT_VALID to accept: 0 cycles when EVT_READY is held high, so EVT_VALID lasts exactly one cycle.
- After RST release: BOOT exits SYNC_STAGES+1 edges later if IN_RST=1.

## Configuration
- RST_EVENT_COUNT_EN defined: the EVT_COUNT register is built as specified.
- RST_EVENT_COUNT_EN undefined: no counter; EVT_COUNT is tied to 0. The port remains, and all other behaviour is unchanged.

## Structure
- Shared package:
  - FSM state typedef (BOOT/IDLE/ASSERTED).
  - Width-of-counter function, clog2(MIN_ASSERT+1).
- One sub-module, rst_sense_sync:
  - Parameterised synchroniser chain with an async clear on (RST & IN_RST).
  - Also used by other cross-domain reset consumers.
- Top level holds the FSM, width counter, event register, sticky flags and the optional counter.

## Test plan
All scenarios use the defaults (SYNC_STAGES=2, MIN_ASSERT=4).
- Local reset: RST=0 for 3 cycles with IN_RST=1 -> IN_RESET=1, other outputs 0; after release, IN_RESET=0 within 2 edges, BOOT->IDLE, no EVT_VALID.
- IN_RST low for 10 cycles then high, EVT_READY=1 -> IN_RESET rises at once and falls 2 edges after release; EVT_VALID high for exactly 1 cycle, 1 cycle later; EVT_COUNT 0->1.
- IN_RST low for 1 ns between edges -> IN_RESET high for 2 cycles, EVT_SHORT=1, no EVT_VALID, EVT_COUNT unchanged; CLR_STICKY pulse -> EVT_SHORT=0.
- Two valid IN_RST cycles with EVT_READY=0 -> EVT_VALID stays 1, OVERRUN=1, EVT_COUNT=2; EVT_READY=1 for 1 cycle -> EVT_VALID=0, OVERRUN stays 1.
- CNT_WIDTH=2, five valid IN_RST cycles -> EVT_COUNT=1. With RST_EVENT_COUNT_EN undefined -> EVT_COUNT=0 throughout.
- RST asserted while in ASSERTED with an event pending -> EVT_VALID=0, EVT_COUNT=0, state BOOT; after release, no spurious event or EVT_SHORT.
